// File: rtl/fill_data_array_pkg.sv
// rtl/fill_data_array_pkg.sv - fill FSM state encoding and default geometry constants
package fill_data_array_pkg;

  localparam int DEF_WORD_W    = 16;
  localparam int DEF_LANES     = 2;
  localparam int DEF_BLK_WORDS = 8;
  localparam int DEF_NUM_BLKS  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/fill_data_array_if.sv
// rtl/fill_data_array_if.sv - CPU access, block fill and status bundle; parity_err exists only with DATA_ARRAY_PARITY_EN
interface fill_data_array_if #(
  parameter int WORD_W    = fill_data_array_pkg::DEF_WORD_W,
  parameter int LANES     = fill_data_array_pkg::DEF_LANES,
  parameter int BLK_WORDS = fill_data_array_pkg::DEF_BLK_WORDS,
  parameter int NUM_BLKS  = fill_data_array_pkg::DEF_NUM_BLKS
) ();

  localparam int BLK_AW = $clog2(NUM_BLKS);
  localparam int WRD_AW = $clog2(BLK_WORDS);

  logic                      req_valid;
  logic [LANES-1:0]          req_wr_lane;
  logic [BLK_AW-1:0]         req_blk;
  logic [WRD_AW-1:0]         req_word;
  logic [LANES*WORD_W-1:0]   req_wdata;
  logic                      rd_valid;
  logic [LANES*WORD_W-1:0]   rd_data;
  logic                      fill_start;
  logic [BLK_AW-1:0]         fill_blk;
  logic                      mem_valid;
  logic [LANES*WORD_W-1:0]   mem_data;
  logic                      busy;
  logic                      fill_done;
`ifdef DATA_ARRAY_PARITY_EN
  logic [LANES-1:0]          parity_err;
`endif

  modport master (
    output req_valid, req_wr_lane, req_blk, req_word, req_wdata,
    output fill_start, fill_blk, mem_valid, mem_data,
`ifdef DATA_ARRAY_PARITY_EN
    input  parity_err,
`endif
    input  rd_valid, rd_data, busy, fill_done
  );

  modport slave (
    input  req_valid, req_wr_lane, req_blk, req_word, req_wdata,
    input  fill_start, fill_blk, mem_valid, mem_data,
`ifdef DATA_ARRAY_PARITY_EN
    output parity_err,
`endif
    output rd_valid, rd_data, busy, fill_done
  );

endinterface

// File: rtl/fill_data_array_bank.sv
// rtl/fill_data_array_bank.sv - one lane of word storage with registered read; adds even parity with DATA_ARRAY_PARITY_EN
module data_array_bank #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 512,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
`ifdef DATA_ARRAY_PARITY_EN
  output logic              rerr,
`endif
  output logic [WORD_W-1:0] rdata
);

`ifdef DATA_ARRAY_PARITY_EN
  localparam int STORE_W = WORD_W + 1;
`else
  localparam int STORE_W = WORD_W;
`endif

  logic [STORE_W-1:0] mem [DEPTH];
  logic [STORE_W-1:0] wword;

  always_comb begin
`ifdef DATA_ARRAY_PARITY_EN
    wword = {^wdata, wdata};
`else
    wword = wdata;
`endif
  end

  // rdata only moves on a read, so it holds between reads
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
`ifdef DATA_ARRAY_PARITY_EN
      rerr  <= 1'b0;
`endif
    end else begin
      if (we) mem[waddr] <= wword;
      if (re) rdata <= mem[raddr][WORD_W-1:0];
`ifdef DATA_ARRAY_PARITY_EN
      rerr <= re & (^mem[raddr]);
`endif
    end
  end

endmodule

// File: rtl/fill_data_array.sv
// rtl/fill_data_array.sv - lane-masked CPU data array with exclusive block-fill engine; DATA_ARRAY_PARITY_EN adds parity_err
module fill_data_array
  import fill_data_array_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int LANES     = DEF_LANES,
  parameter int BLK_WORDS = DEF_BLK_WORDS,
  parameter int NUM_BLKS  = DEF_NUM_BLKS
) (
  input logic               clk,
  input logic               rst,
  fill_data_array_if.slave  bus
);

  localparam int BLK_AW = $clog2(NUM_BLKS);
  localparam int WRD_AW = $clog2(BLK_WORDS);
  localparam int ADDR_W = BLK_AW + WRD_AW;
  localparam int DEPTH  = NUM_BLKS * BLK_WORDS;

  fill_state_e        state_q, state_d;
  logic [WRD_AW-1:0]  cnt_q;
  logic [BLK_AW-1:0]  blk_q;
  logic               rd_valid_q;

  logic               fill_we;
  logic               cpu_ok;
  logic               cpu_rd;
  logic [ADDR_W-1:0]  waddr;
  logic [ADDR_W-1:0]  raddr;
  logic [LANES-1:0]   lane_we;
  logic [LANES*WORD_W-1:0] wdata;
  logic [LANES*WORD_W-1:0] rd_data_w;
`ifdef DATA_ARRAY_PARITY_EN
  logic [LANES-1:0]   par_err_w;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      blk_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= cpu_rd;
      if (state_q == IDLE && bus.fill_start) begin
        blk_q <= bus.fill_blk;
        cnt_q <= '0;
      end else if (fill_we) begin
        cnt_q <= cnt_q + WRD_AW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.fill_start) state_d = FILL;
      FILL:    if (fill_we && cnt_q == WRD_AW'(BLK_WORDS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.fill_done = (state_q == DONE);
  end

  // CPU traffic is only honoured in IDLE, so fill and CPU never share the write port
  always_comb begin
    fill_we = (state_q == FILL) && bus.mem_valid;
    cpu_ok  = (state_q == IDLE) && bus.req_valid;
    cpu_rd  = cpu_ok && (bus.req_wr_lane == '0);
    raddr   = {bus.req_blk, bus.req_word};
    waddr   = fill_we ? {blk_q, cnt_q} : raddr;
    wdata   = fill_we ? bus.mem_data : bus.req_wdata;
    lane_we = fill_we ? {LANES{1'b1}} : ({LANES{cpu_ok}} & bus.req_wr_lane);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    data_array_bank #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH),
      .AW     (ADDR_W)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (lane_we[i]),
      .waddr (waddr),
      .wdata (wdata[i*WORD_W +: WORD_W]),
      .re    (cpu_rd),
      .raddr (raddr),
`ifdef DATA_ARRAY_PARITY_EN
      .rerr  (par_err_w[i]),
`endif
      .rdata (rd_data_w[i*WORD_W +: WORD_W])
    );
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_w;
`ifdef DATA_ARRAY_PARITY_EN
  assign bus.parity_err = par_err_w;
`endif

endmodule

// File: tb/tb_fill_data_array.sv
// tb/tb_fill_data_array.sv - directed scenario bench for fill_data_array; parity scenario runs with DATA_ARRAY_PARITY_EN
module tb_fill_data_array;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  fill_data_array_if #(.WORD_W(16), .LANES(2), .BLK_WORDS(8), .NUM_BLKS(64)) bus ();

  fill_data_array #(.WORD_W(16), .LANES(2), .BLK_WORDS(8), .NUM_BLKS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int blk, input int word, output logic v, output logic [31:0] d);
    bus.req_valid   = 1'b1;
    bus.req_wr_lane = 2'b00;
    bus.req_blk     = 6'(blk);
    bus.req_word    = 3'(word);
    tick();
    bus.req_valid   = 1'b0;
    v = bus.rd_valid;
    d = bus.rd_data;
  endtask

  task automatic do_write(input int blk, input int word, input logic [1:0] mask, input logic [31:0] data);
    bus.req_valid   = 1'b1;
    bus.req_wr_lane = mask;
    bus.req_blk     = 6'(blk);
    bus.req_word    = 3'(word);
    bus.req_wdata   = data;
    tick();
    bus.req_valid   = 1'b0;
    bus.req_wr_lane = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.fill_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: rd_valid=%b busy=%b fill_done=%b expected 0 0 0", bus.rd_valid, bus.busy, bus.fill_done);
    end
    tests_run++;
    if (bus.rd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rd_data: got %h expected 00000000", bus.rd_data);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read_after_reset();
    logic v;
    logic [31:0] d;
    do_read(5, 3, v, d);
    tests_run++;
    if (v !== 1'b1 || d !== 32'h0) begin
      tests_failed++;
      $display("FAIL read_after_reset: rd_valid=%b rd_data=%h expected 1 00000000", v, d);
    end
    tick();
    tests_run++;
    if (bus.rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_valid_drop: got %b expected 0", bus.rd_valid);
    end
  endtask

  task automatic test_masked_write();
    logic v;
    logic [31:0] d;
    do_write(5, 3, 2'b10, 32'hBEEF_1234);
    do_read(5, 3, v, d);
    tests_run++;
    if (v !== 1'b1 || d !== 32'hBEEF_0000) begin
      tests_failed++;
      $display("FAIL masked_write: rd_valid=%b rd_data=%h expected 1 beef0000", v, d);
    end
  endtask

  task automatic test_fill();
    logic v;
    logic [31:0] d;
    logic [15:0] h;
    int idx;
    int done_cnt;
    logic done_now;
    bus.fill_start = 1'b1;
    bus.fill_blk   = 6'd9;
    tick();
    bus.fill_start = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_busy: got %b expected 1", bus.busy);
    end
    idx = 0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 30 && idx < 8; cyc++) begin
      h = 16'(idx);
      bus.mem_valid = !(cyc == 2 || cyc == 5);
      bus.mem_data  = {h, h};
      tick();
      if (bus.mem_valid) idx++;
      if (bus.fill_done) done_cnt++;
    end
    bus.mem_valid = 1'b0;
    done_now = bus.fill_done;
    tests_run++;
    if (idx !== 8 || done_now !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_done_timing: words=%0d fill_done=%b expected 8 1", idx, done_now);
    end
    repeat (3) begin
      tick();
      if (bus.fill_done) done_cnt++;
    end
    tests_run++;
    if (done_cnt !== 1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_done_count: pulses=%0d busy=%b expected 1 0", done_cnt, bus.busy);
    end
    for (int w = 0; w < 8; w++) begin
      h = 16'(w);
      do_read(9, w, v, d);
      tests_run++;
      if (v !== 1'b1 || d !== {h, h}) begin
        tests_failed++;
        $display("FAIL fill_readback[%0d]: rd_valid=%b rd_data=%h expected 1 %h", w, v, d, {h, h});
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic v;
    logic [31:0] d;
    logic [15:0] h;
    int done_cnt;
    // fill_start and a read in the same IDLE cycle: both serviced
    bus.fill_start  = 1'b1;
    bus.fill_blk    = 6'd12;
    bus.req_valid   = 1'b1;
    bus.req_wr_lane = 2'b00;
    bus.req_blk     = 6'd5;
    bus.req_word    = 3'd3;
    tick();
    bus.fill_start  = 1'b0;
    bus.req_valid   = 1'b0;
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hBEEF_0000 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_with_read: rd_valid=%b rd_data=%h busy=%b expected 1 beef0000 1", bus.rd_valid, bus.rd_data, bus.busy);
    end
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      h = 16'(160 + k);
      bus.mem_valid = 1'b1;
      bus.mem_data  = {h, h};
      if (k == 0) begin
        bus.req_valid = 1'b1; bus.req_wr_lane = 2'b11; bus.req_blk = 6'd5; bus.req_word = 3'd3;
        bus.req_wdata = 32'h1111_1111;
      end
      if (k == 1) begin
        bus.fill_start = 1'b1; bus.fill_blk = 6'd5;
      end
      if (k == 2) begin
        bus.req_valid = 1'b1; bus.req_wr_lane = 2'b00; bus.req_blk = 6'd5; bus.req_word = 3'd0;
      end
      tick();
      bus.req_valid   = 1'b0;
      bus.req_wr_lane = 2'b00;
      bus.fill_start  = 1'b0;
      if (k == 3) begin
        tests_run++;
        if (bus.rd_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL busy_read_ignored: rd_valid=%b expected 0", bus.rd_valid);
        end
      end
      if (bus.fill_done) done_cnt++;
    end
    bus.mem_valid = 1'b0;
    repeat (12) begin
      tick();
      if (bus.fill_done) done_cnt++;
    end
    tests_run++;
    if (done_cnt !== 1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_single_done: pulses=%0d busy=%b expected 1 0", done_cnt, bus.busy);
    end
    do_read(5, 3, v, d);
    tests_run++;
    if (d !== 32'hBEEF_0000) begin
      tests_failed++;
      $display("FAIL busy_write_ignored: rd_data=%h expected beef0000", d);
    end
    do_read(12, 7, v, d);
    tests_run++;
    if (d !== 32'h00A7_00A7) begin
      tests_failed++;
      $display("FAIL busy_fill_last: rd_data=%h expected 00a700a7", d);
    end
    do_read(5, 0, v, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL busy_second_fill_ignored: rd_data=%h expected 00000000", d);
    end
  endtask

  task automatic test_reset_midfill();
    logic v;
    logic [31:0] d;
    int done_cnt;
    bus.fill_start = 1'b1;
    bus.fill_blk   = 6'd9;
    tick();
    bus.fill_start = 1'b0;
    bus.mem_valid  = 1'b1;
    bus.mem_data   = 32'hFFFF_FFFF;
    repeat (4) tick();
    bus.mem_valid  = 1'b0;
    rst = 1'b0;
    tick();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.fill_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midfill_reset: busy=%b fill_done=%b expected 0 0", bus.busy, bus.fill_done);
    end
    rst = 1'b1;
    done_cnt = 0;
    repeat (4) begin
      tick();
      if (bus.fill_done) done_cnt++;
    end
    tests_run++;
    if (done_cnt !== 0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midfill_no_done: pulses=%0d busy=%b expected 0 0", done_cnt, bus.busy);
    end
    do_read(9, 1, v, d);
    tests_run++;
    if (v !== 1'b1 || d !== 32'h0) begin
      tests_failed++;
      $display("FAIL midfill_blk9_w1: rd_valid=%b rd_data=%h expected 1 00000000", v, d);
    end
    do_read(9, 5, v, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL midfill_blk9_w5: rd_data=%h expected 00000000", d);
    end
    do_read(5, 3, v, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL midfill_storage_clear: rd_data=%h expected 00000000", d);
    end
  endtask

`ifdef DATA_ARRAY_PARITY_EN
  task automatic test_parity();
    logic v;
    logic [31:0] d;
    do_write(2, 1, 2'b11, 32'h1234_5678);
    do_read(2, 1, v, d);
    tests_run++;
    if (bus.parity_err !== 2'b00) begin
      tests_failed++;
      $display("FAIL parity_clean: parity_err=%b expected 00", bus.parity_err);
    end
    dut.g_lane[0].u_bank.mem[17][0] = ~dut.g_lane[0].u_bank.mem[17][0];
    do_read(2, 1, v, d);
    tests_run++;
    if (v !== 1'b1 || bus.parity_err !== 2'b01 || d !== 32'h1234_5679) begin
      tests_failed++;
      $display("FAIL parity_flip: rd_valid=%b parity_err=%b rd_data=%h expected 1 01 12345679", v, bus.parity_err, d);
    end
  endtask
`endif

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    rst             = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_wr_lane = 2'b00;
    bus.req_blk     = '0;
    bus.req_word    = '0;
    bus.req_wdata   = '0;
    bus.fill_start  = 1'b0;
    bus.fill_blk    = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_data    = '0;
    test_reset();
    test_read_after_reset();
    test_masked_write();
    test_fill();
    test_busy_ignore();
    test_reset_midfill();
`ifdef DATA_ARRAY_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
